// File: rtl/fmap_pkg.sv
// Shared types and constants for the feature-map writer slice.
package fmap_pkg;

  localparam int unsigned DEF_LANES      = 16;
  localparam int unsigned DEF_DATA_WIDTH = 14;
  localparam int unsigned LEN_W          = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/vec_fifo.sv
// Small synchronous vector FIFO; head is exposed combinationally, flags are registered.
// Push while full is accepted when a pop happens in the same cycle.
module vec_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic             full
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok    = pop & not_empty;
  assign push_ok   = push & (~full | pop_ok);
  assign count_nxt = count + CW'(push_ok) - CW'(pop_ok);
  assign head_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      not_empty <= 1'b0;
      full      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count     <= count_nxt;
      not_empty <= (count_nxt != '0);
      full      <= (count_nxt == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/relu_fmap_writer.sv
// Buffers ReLU vectors and writes them to the feature-map SRAM at sequential addresses.
// Optional RELU_FMAP_DROP_CNT_EN adds a saturating dropped-vector counter output.
module relu_fmap_writer
  import fmap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [ADDR_WIDTH-1:0]       cfg_base,
  input  logic [LEN_W-1:0]            cfg_len,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH*LANES-1:0] in_data,
  output logic                        mem_wr_en,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH*LANES-1:0] mem_wdata,
  input  logic                        mem_ready,
  output logic                        busy,
  output logic                        done,
  output logic                        overflow
`ifdef RELU_FMAP_DROP_CNT_EN
  ,
  output logic [LEN_W-1:0]            drop_cnt
`endif
);

  localparam int unsigned VEC_W = DATA_WIDTH * LANES;

  state_e           state;
  state_e           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] acc_cnt;
  logic [LEN_W-1:0] wr_cnt;
  logic             cfg_load;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_valid;
  logic [VEC_W-1:0] fifo_head;

  vec_fifo #(
    .WIDTH (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (fifo_head),
    .not_empty (fifo_valid),
    .full      (fifo_full)
  );

  assign mem_wr_en = fifo_valid;
  assign mem_wdata = fifo_head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state plus push/pop/drop strobes for the datapath.
  always_comb begin
    state_nxt = state;
    cfg_load  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    drop      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cfg_load  = 1'b1;
          state_nxt = (cfg_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        pop = fifo_valid & mem_ready;
        if (in_valid && (acc_cnt < len_q)) begin
          if (!fifo_full || pop) push = 1'b1;
          else                   drop = 1'b1;
        end
        if (pop && ((wr_cnt + LEN_W'(1)) == len_q)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q    <= '0;
      acc_cnt  <= '0;
      wr_cnt   <= '0;
      mem_addr <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);
      if (cfg_load) begin
        len_q    <= cfg_len;
        acc_cnt  <= '0;
        wr_cnt   <= '0;
        mem_addr <= cfg_base;
        overflow <= 1'b0;
      end else begin
        if (push) acc_cnt <= acc_cnt + LEN_W'(1);
        if (pop) begin
          wr_cnt   <= wr_cnt + LEN_W'(1);
          mem_addr <= mem_addr + ADDR_WIDTH'(1);
        end
        if (drop) overflow <= 1'b1;
      end
    end
  end

`ifdef RELU_FMAP_DROP_CNT_EN
  // Saturating count of vectors lost to a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (cfg_load) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + LEN_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_relu_fmap_writer.sv
// Randomized bench for relu_fmap_writer against a queue-based frame model.
module tb_relu_fmap_writer;

  localparam int DW    = 14;
  localparam int LN    = 16;
  localparam int DEPTH = 4;
  localparam int AW    = 12;
  localparam int VW    = DW * LN;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [15:0]   cfg_len;
  logic          in_valid;
  logic [VW-1:0] in_data;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [VW-1:0] mem_wdata;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef RELU_FMAP_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  relu_fmap_writer #(
    .DATA_WIDTH (DW),
    .LANES      (LN),
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_len   (cfg_len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .mem_wr_en (mem_wr_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
`ifdef RELU_FMAP_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_seen;
  int done_seen;

  // Frame-level reference: pending vectors, next address, counts, flags.
  int            m_state;
  logic [VW-1:0] m_q[$];
  logic [AW-1:0] m_addr;
  int unsigned   m_len, m_acc, m_wr, m_drop;
  logic          m_ovf;

  function automatic void model_clear();
    m_state = M_IDLE;
    m_q.delete();
    m_addr = '0;
    m_len = 0; m_acc = 0; m_wr = 0; m_drop = 0;
    m_ovf = 1'b0;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < VW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input logic st, input logic [AW-1:0] base, input logic [15:0] len,
                      input logic v, input logic [VW-1:0] d, input logic rdy);
    bit pop;
    start = st; cfg_base = base; cfg_len = len;
    in_valid = v; in_data = d; mem_ready = rdy;

    checks++;
    if (mem_wr_en !== (m_q.size() > 0)) begin
      errors++; $display("FAIL wr_en t=%0t got %b exp %b", $time, mem_wr_en, m_q.size() > 0);
    end
    checks++;
    if (busy !== (m_state == M_RUN)) begin
      errors++; $display("FAIL busy t=%0t got %b exp %b", $time, busy, m_state == M_RUN);
    end
    checks++;
    if (done !== (m_state == M_DONE)) begin
      errors++; $display("FAIL done t=%0t got %b exp %b", $time, done, m_state == M_DONE);
    end
    checks++;
    if (overflow !== m_ovf) begin
      errors++; $display("FAIL overflow t=%0t got %b exp %b", $time, overflow, m_ovf);
    end
    if (m_q.size() > 0) begin
      checks++;
      if (mem_addr !== m_addr) begin
        errors++; $display("FAIL addr t=%0t got %h exp %h", $time, mem_addr, m_addr);
      end
      checks++;
      if (mem_wdata !== m_q[0]) begin
        errors++; $display("FAIL wdata t=%0t got %h exp %h", $time, mem_wdata, m_q[0]);
      end
    end
`ifdef RELU_FMAP_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'(m_drop)) begin
      errors++; $display("FAIL drop_cnt t=%0t got %0d exp %0d", $time, drop_cnt, m_drop);
    end
`endif
    if (mem_wr_en === 1'b1 && rdy) wr_seen++;
    if (done === 1'b1) done_seen++;

    case (m_state)
      M_IDLE: begin
        if (st) begin
          m_addr = base; m_len = len; m_acc = 0; m_wr = 0; m_drop = 0; m_ovf = 1'b0;
          m_state = (len != 0) ? M_RUN : M_DONE;
        end
      end
      M_RUN: begin
        pop = (m_q.size() > 0) && rdy;
        if (v && m_acc < m_len) begin
          if (m_q.size() < DEPTH || pop) begin
            m_q.push_back(d);
            m_acc++;
          end else begin
            m_ovf = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
        if (pop) begin
          void'(m_q.pop_front());
          m_addr = m_addr + AW'(1);
          m_wr++;
          if (m_wr == m_len) m_state = M_DONE;
        end
      end
      default: m_state = M_IDLE;
    endcase
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 16'd0, 1'b0, '0, rdy);
  endtask

  task automatic send(input logic rdy);
    step(1'b0, '0, 16'd0, 1'b1, rand_vec(), rdy);
  endtask

  task automatic kick(input logic [AW-1:0] base, input logic [15:0] len);
    wr_seen = 0; done_seen = 0;
    step(1'b1, base, len, 1'b0, '0, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_wr_en, busy, done, overflow} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {mem_wr_en, busy, done, overflow});
    end
    checks++;
    if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 000", mem_addr); end
    checks++;
    if (mem_wdata !== '0) begin errors++; $display("FAIL reset_wdata got %h exp 0", mem_wdata); end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic test_basic();
    kick(12'h100, 16'd4);
    for (int i = 0; i < 4; i++) send(1'b1);
    idle(4, 1'b1);
    checks++;
    if (wr_seen != 4) begin errors++; $display("FAIL basic_writes got %0d exp 4", wr_seen); end
    checks++;
    if (done_seen != 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_seen); end
  endtask

  task automatic test_overflow();
    kick(12'h200, 16'd8);
    for (int i = 0; i < 8; i++) send(1'b0);
    idle(2, 1'b0);
    idle(6, 1'b1);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    checks++;
    if (wr_seen != 4 || done_seen != 0) begin
      errors++; $display("FAIL ovf_stall got writes %0d done %0d exp 4 0", wr_seen, done_seen);
    end
`ifdef RELU_FMAP_DROP_CNT_EN
    checks++;
    if (drop_cnt !== 16'd4) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 4", drop_cnt); end
`endif
    // Remaining accepts let the frame finish; overflow stays set until restart.
    for (int i = 0; i < 4; i++) send(1'b1);
    idle(4, 1'b1);
    checks++;
    if (wr_seen != 8 || done_seen != 1) begin
      errors++; $display("FAIL ovf_finish got writes %0d done %0d exp 8 1", wr_seen, done_seen);
    end
    kick(12'h010, 16'd1);
    send(1'b1);
    idle(3, 1'b1);
  endtask

  task automatic test_wrap();
    kick(12'hFFE, 16'd3);
    for (int i = 0; i < 3; i++) send(1'b1);
    idle(4, 1'b1);
    checks++;
    if (wr_seen != 3 || done_seen != 1) begin
      errors++; $display("FAIL wrap got writes %0d done %0d exp 3 1", wr_seen, done_seen);
    end
  endtask

  task automatic test_len0();
    kick(12'h055, 16'd0);
    idle(4, 1'b1);
    checks++;
    if (wr_seen != 0 || done_seen != 1) begin
      errors++; $display("FAIL len0 got writes %0d done %0d exp 0 1", wr_seen, done_seen);
    end
  endtask

  task automatic test_stall_toggle();
    kick(12'h040, 16'd6);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) step(1'b1, 12'h300, 16'd2, 1'b1, rand_vec(), 1'b1);
      else        send(i % 2 == 0);
    end
    for (int i = 0; i < 12; i++) idle(1, i % 2 == 1);
    checks++;
    if (wr_seen != 6 || done_seen != 1) begin
      errors++; $display("FAIL stall got writes %0d done %0d exp 6 1", wr_seen, done_seen);
    end
  endtask

  task automatic test_reset_mid();
    kick(12'h080, 16'd5);
    for (int i = 0; i < 10 && wr_seen < 2; i++) send(1'b1);
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_wr_en, busy, done, overflow} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++; $display("FAIL reset_mid got flags %b addr %h exp 0000 000",
                         {mem_wr_en, busy, done, overflow}, mem_addr);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    idle(2, 1'b1);
    kick(12'h020, 16'd1);
    send(1'b1);
    idle(3, 1'b1);
    checks++;
    if (wr_seen != 1 || done_seen != 1) begin
      errors++; $display("FAIL reset_restart got writes %0d done %0d exp 1 1", wr_seen, done_seen);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      int cyc;
      kick(AW'($urandom), 16'($urandom_range(1, 12)));
      cyc = 0;
      while (m_state != M_IDLE && cyc < 400) begin
        step($urandom_range(0, 19) == 0, AW'($urandom), 16'($urandom_range(0, 5)),
             $urandom_range(0, 9) < 7, rand_vec(), $urandom_range(0, 9) < 6);
        cyc++;
      end
      checks++;
      if (m_state != M_IDLE) begin
        errors++; $display("FAIL random_timeout frame %0d got state %0d exp 0", f, m_state);
        rst = 1'b0; #1; model_clear(); @(negedge clk); rst = 1'b1; @(negedge clk);
      end
      idle($urandom_range(0, 2), 1'b1);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; cfg_base = '0; cfg_len = '0;
    in_valid = 1'b0; in_data = '0; mem_ready = 1'b0;
    model_clear();
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_len0();
    test_stall_toggle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
